// File: rtl/inst_dispatch.sv
// inst_dispatch: decodes host instructions into layer config, DDR load requests and PE task dispatch
module inst_dispatch #(
  parameter int PE_NUM = 32,
  parameter int INST_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ins_valid,
  output logic              ins_ready,
  input  logic [INST_W-1:0] ins,
  output logic [3:0]        layer_type,
  output logic [7:0]        image_width,
  output logic [3:0]        in_ch_seg,
  output logic              ddr2pe_ins_valid,
  input  logic              ddr2pe_ins_ready,
  output logic [INST_W-1:0] ddr2pe_ins,
  output logic [PE_NUM-1:0] start,
  input  logic [PE_NUM-1:0] done,
  output logic [2:0]        mode,
  output logic [7:0]        idx_cnt,
  output logic [7:0]        trip_cnt,
  output logic              is_new,
  output logic [3:0]        pad_code,
  output logic              cut_y,
  output logic [PE_NUM-1:0] pe_busy,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, S_CFG, S_LOAD, S_COMP, S_SYNC} state_t;
  state_t state, state_nx;
  logic [INST_W-1:0] ir;
  logic [PE_NUM-1:0] pe_mask;
  logic [3:0] op;
  logic take, conflict, issue;
  assign op = ins[63:60];
  assign take = ins_valid && ins_ready;
  assign pe_mask = ir[28 +: PE_NUM];
  assign conflict = |(pe_mask & pe_busy);
  assign issue = (state == S_COMP) && !conflict;
  assign ins_ready = (state == IDLE) && !rst;
  assign ddr2pe_ins_valid = (state == S_LOAD);
  assign ddr2pe_ins = ddr2pe_ins_valid ? ir : '0;
  // next state: one instruction in flight; each op state falls back to IDLE once its work completes
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !take ? IDLE : op == 4'd0 ? S_CFG : op == 4'd1 ? S_LOAD :
                          op == 4'd2 ? S_COMP : op == 4'd3 ? S_SYNC : IDLE;
      S_CFG:   state_nx = IDLE;
      S_LOAD:  state_nx = ddr2pe_ins_ready ? IDLE : S_LOAD;
      S_COMP:  state_nx = conflict ? S_COMP : IDLE;
      S_SYNC:  state_nx = |pe_busy ? S_SYNC : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // legal instructions are captured on handshake; illegal opcodes are dropped and raise the sticky error
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ir <= '0;
      err <= 1'b0;
    end else if (take) begin
      if (op[3:2] == 2'b00) ir <= ins;
      else err <= 1'b1;
    end
  // layer configuration registers, written on the cycle spent in S_CFG
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      layer_type <= '0;
      image_width <= '0;
      in_ch_seg <= '0;
    end else if (state == S_CFG) begin
      layer_type <= ir[59:56];
      image_width <= ir[55:48];
      in_ch_seg <= ir[47:44];
    end
  // task issue: start pulse, shared task fields and busy tracking (done clears, issue sets)
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      start <= '0;
      pe_busy <= '0;
      mode <= '0;
      idx_cnt <= '0;
      trip_cnt <= '0;
      is_new <= 1'b0;
      pad_code <= '0;
      cut_y <= 1'b0;
    end else begin
      start <= issue ? pe_mask : '0;
      pe_busy <= (pe_busy & ~done) | (issue ? pe_mask : '0);
      if (issue) begin
        mode <= ir[27:25];
        idx_cnt <= ir[24:17];
        trip_cnt <= ir[16:9];
        is_new <= ir[8];
        pad_code <= ir[7:4];
        cut_y <= ir[3];
      end
    end
endmodule

// File: tb/tb_inst_dispatch.sv
// tb_inst_dispatch: directed and randomized instruction sequences checked against a transaction-level model
module tb_inst_dispatch;
  localparam int P = 32;
  localparam int W = 64;
  logic clk = 1'b0, rst = 1'b1;
  logic ins_valid = 1'b0, ins_ready;
  logic [W-1:0] ins = '0;
  logic [3:0] layer_type, in_ch_seg, pad_code;
  logic [7:0] image_width, idx_cnt, trip_cnt;
  logic ddr2pe_ins_valid, ddr2pe_ins_ready = 1'b0;
  logic [W-1:0] ddr2pe_ins;
  logic [P-1:0] start, pe_busy, done = '0;
  logic [2:0] mode;
  logic is_new, cut_y, err;
  int total = 0, passed = 0;
  logic [3:0] m_lt, m_ics, m_pad;
  logic [7:0] m_iw, m_idx, m_trip;
  logic [2:0] m_mode;
  logic m_new, m_cut, m_err;
  logic [P-1:0] m_busy;
  logic [W-1:0] x;
  logic [P-1:0] rmask;
  logic [2:0] s_mode;
  logic [7:0] s_idx, s_trip;
  logic [3:0] s_pad;
  logic s_new, s_cut;

  inst_dispatch #(.PE_NUM(P), .INST_W(W)) dut (
    .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins),
    .layer_type(layer_type), .image_width(image_width), .in_ch_seg(in_ch_seg),
    .ddr2pe_ins_valid(ddr2pe_ins_valid), .ddr2pe_ins_ready(ddr2pe_ins_ready), .ddr2pe_ins(ddr2pe_ins),
    .start(start), .done(done), .mode(mode), .idx_cnt(idx_cnt), .trip_cnt(trip_cnt),
    .is_new(is_new), .pad_code(pad_code), .cut_y(cut_y), .pe_busy(pe_busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic chk_state(input string tag, input logic [P-1:0] es, input logic ev, input logic er);
    chk({tag, ".start"}, start, es);
    chk({tag, ".ddr_valid"}, ddr2pe_ins_valid, ev);
    chk({tag, ".ins_ready"}, ins_ready, er);
    chk({tag, ".layer_type"}, layer_type, m_lt);
    chk({tag, ".image_width"}, image_width, m_iw);
    chk({tag, ".in_ch_seg"}, in_ch_seg, m_ics);
    chk({tag, ".mode"}, mode, m_mode);
    chk({tag, ".idx_cnt"}, idx_cnt, m_idx);
    chk({tag, ".trip_cnt"}, trip_cnt, m_trip);
    chk({tag, ".is_new"}, is_new, m_new);
    chk({tag, ".pad_code"}, pad_code, m_pad);
    chk({tag, ".cut_y"}, cut_y, m_cut);
    chk({tag, ".pe_busy"}, pe_busy, m_busy);
    chk({tag, ".err"}, err, m_err);
  endtask

  task automatic m_reset();
    {m_lt, m_iw, m_ics, m_mode, m_idx, m_trip, m_new, m_pad, m_cut, m_err} = '0;
    m_busy = '0;
  endtask

  task automatic m_task(input logic [2:0] md, input logic [7:0] ix, input logic [7:0] tr,
                        input logic nw, input logic [3:0] pd, input logic ct);
    m_mode = md; m_idx = ix; m_trip = tr; m_new = nw; m_pad = pd; m_cut = ct;
  endtask

  function automatic logic [W-1:0] mk_op(input logic [3:0] op);
    logic [W-1:0] r;
    r = {$urandom, $urandom};
    r[63:60] = op;
    return r;
  endfunction

  // send: present one instruction at a negedge; returns at the following negedge
  task automatic send(input logic [W-1:0] v);
    int n;
    n = 0;
    while (!ins_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send.ready_wait", ins_ready, 1'b1);
    ins_valid = 1'b1;
    ins = v;
    @(negedge clk);
    ins_valid = 1'b0;
    ins = {$urandom, $urandom};
  endtask

  task automatic do_cfg(input logic [3:0] lt, input logic [7:0] iw, input logic [3:0] ics);
    logic [W-1:0] v;
    v = mk_op(4'd0);
    v[59:56] = lt; v[55:48] = iw; v[47:44] = ics;
    send(v);
    chk_state("cfg.n1", '0, 1'b0, 1'b0);
    m_lt = lt; m_iw = iw; m_ics = ics;
    @(negedge clk);
    chk_state("cfg.n2", '0, 1'b0, 1'b1);
  endtask

  task automatic do_load(input int w);
    logic [W-1:0] v;
    v = mk_op(4'd1);
    send(v);
    for (int i = 0; i <= w; i++) begin
      chk_state("load.wait", '0, 1'b1, 1'b0);
      chk("load.data", ddr2pe_ins, v);
      if (i == w) ddr2pe_ins_ready = 1'b1;
      @(negedge clk);
    end
    ddr2pe_ins_ready = 1'b0;
    chk_state("load.done", '0, 1'b0, 1'b1);
  endtask

  function automatic logic [W-1:0] mk_comp(input logic [P-1:0] mask, input logic [2:0] md,
      input logic [7:0] ix, input logic [7:0] tr, input logic nw, input logic [3:0] pd, input logic ct);
    logic [W-1:0] r;
    r = mk_op(4'd2);
    r[28 +: P] = mask; r[27:25] = md; r[24:17] = ix; r[16:9] = tr; r[8] = nw; r[7:4] = pd; r[3] = ct;
    return r;
  endfunction

  // conflict-free COMP; d is pulsed on done during the dispatch cycle (never overlapping mask)
  task automatic do_comp(input logic [P-1:0] mask, input logic [2:0] md, input logic [7:0] ix, input logic [P-1:0] d);
    logic [7:0] tr;
    logic nw, ct;
    logic [3:0] pd;
    tr = 8'($urandom); nw = 1'($urandom); pd = 4'($urandom); ct = 1'($urandom);
    send(mk_comp(mask, md, ix, tr, nw, pd, ct));
    chk_state("comp.n1", '0, 1'b0, 1'b0);
    done = d & ~mask;
    @(negedge clk);
    m_busy = (m_busy & ~(d & ~mask)) | mask;
    done = '0;
    m_task(md, ix, tr, nw, pd, ct);
    chk_state("comp.n2", mask, 1'b0, 1'b1);
    @(negedge clk);
    chk_state("comp.n3", '0, 1'b0, 1'b1);
  endtask

  task automatic pulse_done(input logic [P-1:0] d);
    done = d;
    @(negedge clk);
    done = '0;
    m_busy = m_busy & ~d;
    chk_state("done", '0, 1'b0, 1'b1);
  endtask

  // SYNC: retire busy PEs lowest-first, one done every gap+1 cycles
  task automatic do_sync(input int gap);
    logic [P-1:0] d;
    send(mk_op(4'd3));
    for (int k = 0; k < 200; k++) begin
      chk("sync.ready", ins_ready, 1'b0);
      chk("sync.busy", pe_busy, m_busy);
      if (m_busy == '0) break;
      d = (k % (gap + 1) == gap) ? (m_busy & (~m_busy + 1'b1)) : '0;
      done = d;
      @(negedge clk);
      done = '0;
      m_busy = m_busy & ~d;
    end
    @(negedge clk);
    chk_state("sync.exit", '0, 1'b0, 1'b1);
  endtask

  task automatic do_illegal(input logic [3:0] op);
    send(mk_op(op));
    m_err = 1'b1;
    chk_state("illegal", '0, 1'b0, 1'b1);
  endtask

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    chk_state("reset", '0, 1'b0, 1'b0);
    chk("reset.ddr_ins", ddr2pe_ins, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.release_ready", ins_ready, 1'b1);
    do_cfg(4'd3, 8'h20, 4'd5);
    do_load(5);
    do_comp(32'hF, 3'd2, 8'd9, '0);
    s_mode = 3'($urandom); s_idx = 8'($urandom); s_trip = 8'($urandom);
    s_new = 1'($urandom); s_pad = 4'($urandom); s_cut = 1'($urandom);
    send(mk_comp(32'h3, s_mode, s_idx, s_trip, s_new, s_pad, s_cut));
    repeat (3) begin
      chk_state("stall", '0, 1'b0, 1'b0);
      @(negedge clk);
    end
    done = 32'h1;
    @(negedge clk);
    done = '0;
    m_busy = 32'hE;
    chk_state("stall.d0", '0, 1'b0, 1'b0);
    @(negedge clk);
    chk_state("stall.d0b", '0, 1'b0, 1'b0);
    done = 32'h2;
    @(negedge clk);
    done = '0;
    m_busy = 32'hC;
    chk_state("stall.d1", '0, 1'b0, 1'b0);
    @(negedge clk);
    m_busy = 32'hF;
    m_task(s_mode, s_idx, s_trip, s_new, s_pad, s_cut);
    chk_state("stall.go", 32'h3, 1'b0, 1'b1);
    @(negedge clk);
    chk_state("stall.after", '0, 1'b0, 1'b1);
    pulse_done(32'hA);
    chk("sync.pre_busy", pe_busy, 32'h5);
    do_sync(2);
    do_illegal(4'd7);
    do_cfg(4'($urandom), 8'($urandom), 4'($urandom));
    do_comp('0, 3'($urandom), 8'($urandom), '0);
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 5))
        0: do_cfg(4'($urandom), 8'($urandom), 4'($urandom));
        1: do_load(int'($urandom_range(0, 4)));
        2: begin
          rmask = $urandom & $urandom & ~m_busy;
          do_comp(rmask, 3'($urandom), 8'($urandom), $urandom);
        end
        3: pulse_done($urandom);
        4: do_illegal(4'($urandom_range(4, 15)));
        default: do_sync(int'($urandom_range(0, 2)));
      endcase
    end
    x = mk_op(4'd1);
    send(x);
    chk("rstload.valid", ddr2pe_ins_valid, 1'b1);
    rst = 1'b1;
    #1;
    m_reset();
    chk_state("rstload.in", '0, 1'b0, 1'b0);
    chk("rstload.ddr_ins", ddr2pe_ins, '0);
    @(negedge clk);
    rst = 1'b0;
    ddr2pe_ins_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_state("rstload.after", '0, 1'b0, 1'b1);
    end
    ddr2pe_ins_ready = 1'b0;
    do_illegal(4'($urandom_range(4, 15)));
    do_comp(32'hFF, 3'($urandom), 8'($urandom), '0);
    send(mk_comp(32'h1, 3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom), 1'($urandom)));
    repeat (2) begin
      chk_state("rstcomp.stall", '0, 1'b0, 1'b0);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    m_reset();
    chk_state("rstcomp.in", '0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_state("rstcomp.after", '0, 1'b0, 1'b1);
    do_cfg(4'($urandom), 8'($urandom), 4'($urandom));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/inst_dispatch.md
INST_DISPATCH -- requirements
Module: inst_dispatch

Interface
REQ-001 Parameter PE_NUM, default 32, number of PEs; legal range 4..32, multiple of 4.
REQ-002 Parameter INST_W, default 64, instruction width.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 ins_valid / ins_ready / ins  in / out / in  1 / 1 / INST_W  host instruction stream, valid/ready handshake.
REQ-006 layer_type / image_width / in_ch_seg  out  4 / 8 / 4  layer configuration registers.
REQ-007 ddr2pe_ins_valid / ddr2pe_ins_ready / ddr2pe_ins  out / in / out  1 / 1 / INST_W  load-instruction channel to the DDR loader.
REQ-008 start  out  PE_NUM  per-PE one-cycle start pulse.
REQ-009 done  in  PE_NUM  per-PE one-cycle completion pulse.
REQ-010 mode / idx_cnt / trip_cnt / is_new / pad_code / cut_y  out  3 / 8 / 8 / 1 / 4 / 1  shared PE task fields.
REQ-011 pe_busy  out  PE_NUM  outstanding-task mask.
REQ-012 err  out  1  sticky illegal-opcode flag.

Function
REQ-013 Opcode is ins[63:60]: 0 CFG, 1 LOAD, 2 COMP, 3 SYNC; 4..15 illegal.
REQ-014 CFG fields: layer_type ins[59:56], image_width ins[55:48], in_ch_seg ins[47:44].
REQ-015 COMP fields: pe_mask ins[28+PE_NUM-1:28], mode ins[27:25], idx_cnt ins[24:17], trip_cnt ins[16:9], is_new ins[8], pad_code ins[7:4], cut_y ins[3]; unused bits ignored.
REQ-016 States: IDLE, S_CFG, S_LOAD, S_COMP, S_SYNC; ins_ready = (state==IDLE) and not in reset.
REQ-017 Handshake in cycle N latches ins into an instruction register and enters the opcode's state at N+1; an illegal opcode sets err, stays IDLE, instruction dropped.
REQ-018 S_CFG: config registers load at N+1 edge, visible N+2; return to IDLE (ins_ready high at N+2).
REQ-019 S_LOAD: ddr2pe_ins_valid high, ddr2pe_ins = latched instruction, both stable until ddr2pe_ins_ready sampled high; return to IDLE next cycle.
REQ-020 S_COMP: conflict = |(pe_mask & pe_busy); while conflict, stay in S_COMP with start=0.
REQ-021 S_COMP without conflict: start = pe_mask for exactly one cycle (registered), task fields updated in the same cycle and held until the next COMP; pe_busy |= pe_mask; return to IDLE.
REQ-022 pe_mask = 0: no start pulse, task fields still updated, return to IDLE.
REQ-023 done[i] clears pe_busy[i]; done on a non-busy PE ignored; done and start on different PEs in one cycle both take effect.
REQ-024 done[i] arriving in the cycle conflict is evaluated clears that conflict in the following cycle (conflict uses registered pe_busy).
REQ-025 S_SYNC: remain until pe_busy == 0 and no S_LOAD transfer is pending; return to IDLE the cycle after pe_busy reads zero.
REQ-026 err clears only on reset.

Reset
REQ-027 rst asserted at any time: state IDLE, all outputs 0 (including start, pe_busy, ddr2pe_ins_valid, err, config and task fields), instruction register 0.
REQ-028 Reset mid-LOAD drops the instruction; no ddr2pe transfer completes for it.
REQ-029 ins_ready rises the first cycle after rst deasserts.

Verification
REQ-030 CFG ins=0x0_3_20_5_... -> layer_type=3, image_width=0x20, in_ch_seg=5 at N+2; ins_ready low only at N+1.
REQ-031 LOAD with ddr2pe_ins_ready held low 5 cycles -> ddr2pe_ins_valid high 6 cycles, data stable, ins_ready high the cycle after transfer.
REQ-032 COMP mask=0x0000000F, mode=2, idx_cnt=9 -> start=0xF for one cycle, pe_busy=0xF; second COMP mask=0x3 stalls until done[1:0] both pulsed, then start=0x3.
REQ-033 SYNC with pe_busy=0x5; done[0] then done[2] three cycles apart -> ins_ready rises the cycle after pe_busy reads 0.
REQ-034 Opcode 0x7 -> err=1, no outputs change, next instruction accepted normally; err remains 1 until rst.
REQ-035 rst pulsed during S_COMP stall with pe_busy=0xFF -> all outputs 0, ins_ready high after release.
